// File: rtl/rv_mem_pkg.sv
// Shared load/store encodings, FSM state type and alignment helper for the
// RV32I memory-stage access unit.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the data-memory port: store byte enables and lane
// replication, and load lane select with sign/zero extension.
module lsu_align (
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);
  import rv_mem_pkg::*;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = ld_word_i[{ld_addr_lo_i, 3'b000} +: 8];
  assign ld_half = ld_addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_funct3_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data_o = '0;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'b0, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'b0, ld_half};
      F3_W:    ld_data_o = ld_word_i;
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_access_stage.sv
// Memory-stage load/store unit: issues one req/ready transaction per M-stage
// access, stalls the pipeline while it is outstanding, flags misalignment and timeouts.
module dmem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_readM,
  input  logic        mem_writeM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALU_resultM,
  input  logic [31:0] write_dataM,
  output logic [31:0] read_dataM,
  output logic        stallM,
  output logic        misalignedM,
  output logic        access_faultM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);
  import rv_mem_pkg::*;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             fault_q, fault_d;

  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;

  logic        is_op, misal, issue, latch_en;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;
  logic        req_c, stall_c, mis_c, fault_c, we_c;
  logic [31:0] rd_c, addr_c, wdata_c;
  logic [3:0]  be_c;

  assign is_op = (mem_readM | mem_writeM) &
                 (funct3M inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misal = is_op & is_misaligned(funct3M, ALU_resultM[1:0]);
  assign issue = is_op & ~misal;

  lsu_align u_align (
    .st_funct3_i  (funct3M),
    .st_addr_lo_i (ALU_resultM[1:0]),
    .st_data_i    (write_dataM),
    .st_be_o      (st_be),
    .st_wdata_o   (st_wdata),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (lo_q),
    .ld_word_i    (rdata_q),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    latch_en = 1'b0;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    mis_c    = 1'b0;
    fault_c  = 1'b0;
    rd_c     = '0;
    we_c     = 1'b0;
    addr_c   = '0;
    be_c     = '0;
    wdata_c  = '0;
    case (state_q)
      IDLE: begin
        if (misal) begin
          mis_c = 1'b1;
        end else if (issue) begin
          req_c    = 1'b1;
          stall_c  = 1'b1;
          latch_en = 1'b1;
          we_c     = mem_writeM;
          addr_c   = {ALU_resultM[31:2], 2'b00};
          be_c     = st_be;
          wdata_c  = st_wdata;
          if (dmem_ready) begin
            state_d = DONE;
            rdata_d = dmem_rdata;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        we_c    = we_q;
        addr_c  = addr_q;
        be_c    = be_q;
        wdata_c = wdata_q;
        if (dmem_ready) begin
          state_d = DONE;
          rdata_d = dmem_rdata;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = DONE;
          fault_d = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        fault_c = fault_q;
        rd_c    = we_q ? '0 : ld_data;
        fault_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: the request payload is left unreset; it is only read in WAIT/DONE,
  // which can only be entered through the IDLE cycle that loads it.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      we_q    <= mem_writeM;
      addr_q  <= {ALU_resultM[31:2], 2'b00};
      be_q    <= st_be;
      wdata_q <= st_wdata;
      f3_q    <= funct3M;
      lo_q    <= ALU_resultM[1:0];
    end
  end

  // Pipeline-facing outputs are forced quiet during reset, including mid-WAIT.
  assign dmem_req      = req_c & ~reset;
  assign stallM        = stall_c & ~reset;
  assign misalignedM   = mis_c & ~reset;
  assign access_faultM = fault_c & ~reset;
  assign read_dataM    = reset ? '0 : rd_c;
  assign dmem_we       = we_c;
  assign dmem_addr     = addr_c;
  assign dmem_be       = be_c;
  assign dmem_wdata    = wdata_c;

endmodule
